// File: rtl/tcdm_bank_pkg.sv
// Shared types and helpers for the per-bank TCDM arbiter and its response pipeline.
package tcdm_bank_pkg;

  typedef enum logic {
    PortA = 1'b0,
    PortB = 1'b1
  } port_e;

  // A zero-width counter is illegal, so MaxStall=0 still gets one (always-zero) bit.
  function automatic int unsigned stall_cnt_width(input int unsigned max_stall);
    return (max_stall > 0) ? $clog2(max_stall + 1) : 1;
  endfunction

endpackage

// File: rtl/tcdm_bank_resp_pipe.sv
// Fixed-depth shift register of response tags, aligned with the SRAM read latency.
module tcdm_bank_resp_pipe #(
  parameter int unsigned Depth = 1,
  parameter type         tag_t = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < int'(Depth); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Shares one fixed-latency SRAM bank between an interconnect port (A) and a side port (B),
// routing each read/write response back to its originating port.
module tcdm_bank_arbiter
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned IniAddWidth  = 5,
  parameter int unsigned MemLatency   = 1,
  parameter int unsigned MaxStall     = 3,
  parameter bit          WriteRespOn  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // port A: interconnect target port
  input  logic                    req_a_i,
  output logic                    gnt_a_o,
  input  logic [IniAddWidth-1:0]  ini_add_a_i,
  input  logic [AddrMemWidth-1:0] add_a_i,
  input  logic                    wen_a_i,
  input  logic [DataWidth-1:0]    wdata_a_i,
  input  logic [BeWidth-1:0]      be_a_i,
  output logic                    vld_a_o,
  output logic [IniAddWidth-1:0]  ini_add_a_o,
  output logic [DataWidth-1:0]    rdata_a_o,
  // port B: side port
  input  logic                    req_b_i,
  output logic                    gnt_b_o,
  input  logic [AddrMemWidth-1:0] add_b_i,
  input  logic                    wen_b_i,
  input  logic [DataWidth-1:0]    wdata_b_i,
  input  logic [BeWidth-1:0]      be_b_i,
  output logic                    vld_b_o,
  output logic [DataWidth-1:0]    rdata_b_o,
  // SRAM bank
  output logic                    mem_req_o,
  output logic [AddrMemWidth-1:0] mem_add_o,
  output logic                    mem_wen_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [BeWidth-1:0]      mem_be_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int unsigned StallW = stall_cnt_width(MaxStall);
  localparam logic [StallW-1:0] StallMax = StallW'(MaxStall);

  // The write flag lets write responses return zero data regardless of what the SRAM drives.
  typedef struct packed {
    logic                   valid;
    port_e                  port_sel;
    logic                   wr;
    logic [IniAddWidth-1:0] ini_add;
  } resp_tag_t;

  logic [StallW-1:0] stall_q, stall_d;
  logic              gnt_a, gnt_b;
  resp_tag_t         tag_in, tag_out;

  // Grants are held low during reset so every output reads 0 while rst_ni is asserted.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_ni) begin
      if (req_a_i && req_b_i) begin
        if (stall_q == StallMax) begin
          gnt_b = 1'b1;
        end else begin
          gnt_a = 1'b1;
        end
      end else if (req_a_i) begin
        gnt_a = 1'b1;
      end else if (req_b_i) begin
        gnt_b = 1'b1;
      end
    end
  end

  assign gnt_a_o = gnt_a;
  assign gnt_b_o = gnt_b;

  always_comb begin
    mem_req_o   = gnt_a | gnt_b;
    mem_add_o   = '0;
    mem_wen_o   = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (gnt_a) begin
      mem_add_o   = add_a_i;
      mem_wen_o   = wen_a_i;
      mem_wdata_o = wdata_a_i;
      mem_be_o    = be_a_i;
    end else if (gnt_b) begin
      mem_add_o   = add_b_i;
      mem_wen_o   = wen_b_i;
      mem_wdata_o = wdata_b_i;
      mem_be_o    = be_b_i;
    end
  end

  // Stall counter: counts consecutive cycles B waits, saturating at MaxStall.
  always_comb begin
    stall_d = stall_q;
    if (!req_b_i || gnt_b) begin
      stall_d = '0;
    end else if (stall_q != StallMax) begin
      stall_d = stall_q + StallW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  always_comb begin
    tag_in          = '0;
    tag_in.valid    = mem_req_o & (~mem_wen_o | WriteRespOn);
    tag_in.port_sel = gnt_b ? PortB : PortA;
    tag_in.wr       = mem_wen_o;
    tag_in.ini_add  = ini_add_a_i;
  end

  tcdm_bank_resp_pipe #(
    .Depth (MemLatency),
    .tag_t (resp_tag_t)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tag_i  (tag_in),
    .tag_o  (tag_out)
  );

  always_comb begin
    vld_a_o     = 1'b0;
    vld_b_o     = 1'b0;
    ini_add_a_o = '0;
    rdata_a_o   = '0;
    rdata_b_o   = '0;
    if (tag_out.valid) begin
      if (tag_out.port_sel == PortA) begin
        vld_a_o     = 1'b1;
        ini_add_a_o = tag_out.ini_add;
        if (!tag_out.wr) rdata_a_o = mem_rdata_i;
      end else begin
        vld_b_o = 1'b1;
        if (!tag_out.wr) rdata_b_o = mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench: three arbiter instances with different latency/priority settings share one
// stimulus; each SRAM model returns {20'hC0DE0, address} on reads and 0 on writes.
module tb_tcdm_bank_arbiter;

  localparam int NDut = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_a, wen_a, req_b, wen_b;
  logic [4:0]  ini_add_a;
  logic [11:0] add_a, add_b;
  logic [31:0] wdata_a, wdata_b;
  logic [3:0]  be_a, be_b;

  logic        gnt_a [NDut];
  logic        gnt_b [NDut];
  logic        vld_a [NDut];
  logic        vld_b [NDut];
  logic [4:0]  ini_add_o [NDut];
  logic [31:0] rdata_a [NDut];
  logic [31:0] rdata_b [NDut];
  logic        mem_req [NDut];
  logic [11:0] mem_add [NDut];
  logic        mem_wen [NDut];
  logic [31:0] mem_wdata [NDut];
  logic [3:0]  mem_be [NDut];
  logic [31:0] mem_rdata [NDut];

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // dut0: latency 1, MaxStall 3, no write response
  // dut1: latency 2, MaxStall 3, write response
  // dut2: latency 3, MaxStall 0, write response
  for (genvar gi = 0; gi < NDut; gi++) begin : g_dut
    localparam int Lat  = (gi == 0) ? 1 : (gi == 1) ? 2 : 3;
    localparam int Stl  = (gi == 2) ? 0 : 3;
    localparam bit WrOn = (gi != 0);

    logic [31:0] dly [Lat];

    always_ff @(posedge clk) begin
      dly[0] <= (mem_req[gi] && !mem_wen[gi]) ? {20'hC0DE0, mem_add[gi]} : 32'h0;
      for (int k = 1; k < Lat; k++) dly[k] <= dly[k-1];
    end
    assign mem_rdata[gi] = dly[Lat-1];

    tcdm_bank_arbiter #(
      .AddrMemWidth (12),
      .DataWidth    (32),
      .BeWidth      (4),
      .IniAddWidth  (5),
      .MemLatency   (Lat),
      .MaxStall     (Stl),
      .WriteRespOn  (WrOn)
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_a_i     (req_a),
      .gnt_a_o     (gnt_a[gi]),
      .ini_add_a_i (ini_add_a),
      .add_a_i     (add_a),
      .wen_a_i     (wen_a),
      .wdata_a_i   (wdata_a),
      .be_a_i      (be_a),
      .vld_a_o     (vld_a[gi]),
      .ini_add_a_o (ini_add_o[gi]),
      .rdata_a_o   (rdata_a[gi]),
      .req_b_i     (req_b),
      .gnt_b_o     (gnt_b[gi]),
      .add_b_i     (add_b),
      .wen_b_i     (wen_b),
      .wdata_b_i   (wdata_b),
      .be_b_i      (be_b),
      .vld_b_o     (vld_b[gi]),
      .rdata_b_o   (rdata_b[gi]),
      .mem_req_o   (mem_req[gi]),
      .mem_add_o   (mem_add[gi]),
      .mem_wen_o   (mem_wen[gi]),
      .mem_wdata_o (mem_wdata[gi]),
      .mem_be_o    (mem_be[gi]),
      .mem_rdata_i (mem_rdata[gi])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-24s observed %0h expected %0h ok", tag, obs, exp);
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outputs(input int d);
    return 128'({gnt_a[d], gnt_b[d], vld_a[d], vld_b[d], ini_add_o[d], rdata_a[d], rdata_b[d],
                 mem_req[d], mem_add[d], mem_wen[d], mem_wdata[d], mem_be[d]});
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_a = 1'b0;
    req_b = 1'b0;
    wen_a = 1'b0;
    wen_b = 1'b0;
    repeat (n) next_cycle();
  endtask

  initial begin
    req_a = 0; wen_a = 0; ini_add_a = '0; add_a = '0; wdata_a = '0; be_a = '0;
    req_b = 0; wen_b = 0; add_b = '0; wdata_b = '0; be_b = '0;

    // reset state
    next_cycle();
    @(negedge clk);
    for (int d = 0; d < NDut; d++) check($sformatf("reset_outputs_dut%0d", d), all_outputs(d), '0);
    next_cycle();
    rst_n = 1'b1;
    idle(2);

    // 1: single A read, latency 1
    req_a = 1; add_a = 12'h010; ini_add_a = 5'd7; wen_a = 0;
    @(negedge clk);
    check("t1_gnt_a", 128'(gnt_a[0]), 128'd1);
    check("t1_gnt_b", 128'(gnt_b[0]), 128'd0);
    check("t1_mem_req", 128'(mem_req[0]), 128'd1);
    check("t1_mem_add", 128'(mem_add[0]), 128'h010);
    next_cycle();
    req_a = 0;
    @(negedge clk);
    check("t1_vld_a", 128'(vld_a[0]), 128'd1);
    check("t1_ini_add", 128'(ini_add_o[0]), 128'd7);
    check("t1_rdata_a", 128'(rdata_a[0]), 128'hC0DE0010);
    check("t1_vld_b", 128'(vld_b[0]), 128'd0);
    idle(3);

    // 2: both ports request every cycle, MaxStall=3 -> A,A,A,B repeating
    for (int i = 0; i <= 8; i++) begin
      req_a = (i < 8); req_b = (i < 8);
      add_a = 12'h0A0; add_b = 12'h0B0; wen_a = 0; wen_b = 0; ini_add_a = 5'd2;
      @(negedge clk);
      if (i < 8)
        check($sformatf("t2_gnt_ab_c%0d", i), 128'({gnt_a[0], gnt_b[0]}),
              (i % 4 == 3) ? 128'b01 : 128'b10);
      if (i >= 1) begin
        check($sformatf("t2_vld_b_c%0d", i), 128'(vld_b[0]), 128'((i - 1) % 4 == 3));
        check($sformatf("t2_rdata_b_c%0d", i), 128'(rdata_b[0]),
              ((i - 1) % 4 == 3) ? 128'hC0DE00B0 : 128'h0);
      end
      next_cycle();
    end
    idle(3);

    // 3: A write; no response on dut0, zero-data response on dut1
    req_a = 1; wen_a = 1; add_a = 12'h003; be_a = 4'hF; wdata_a = 32'hDEADBEEF; ini_add_a = 5'd5;
    @(negedge clk);
    check("t3_mem_wen", 128'(mem_wen[0]), 128'd1);
    check("t3_mem_add", 128'(mem_add[0]), 128'h003);
    check("t3_mem_wdata", 128'(mem_wdata[0]), 128'hDEADBEEF);
    check("t3_mem_be", 128'(mem_be[0]), 128'hF);
    next_cycle();
    req_a = 0; wen_a = 0;
    @(negedge clk);
    check("t3_no_vld_a_c1", 128'(vld_a[0]), 128'd0);
    next_cycle();
    @(negedge clk);
    check("t3_no_vld_a_c2", 128'(vld_a[0]), 128'd0);
    check("t3_wresp_vld_dut1", 128'(vld_a[1]), 128'd1);
    check("t3_wresp_ini_dut1", 128'(ini_add_o[1]), 128'd5);
    check("t3_wresp_rdata_dut1", 128'(rdata_a[1]), 128'd0);
    idle(4);

    // 4: back-to-back reads, latency 2
    for (int i = 0; i <= 6; i++) begin
      req_a = (i < 4); wen_a = 0; add_a = 12'(12'h100 + i); ini_add_a = 5'(i);
      @(negedge clk);
      if (i >= 2 && i <= 5) begin
        check($sformatf("t4_vld_a_c%0d", i), 128'(vld_a[1]), 128'd1);
        check($sformatf("t4_ini_add_c%0d", i), 128'(ini_add_o[1]), 128'(i - 2));
        check($sformatf("t4_rdata_a_c%0d", i), 128'(rdata_a[1]), 128'(32'hC0DE0100 + i - 2));
      end else if (i == 6) begin
        check("t4_vld_a_c6", 128'(vld_a[1]), 128'd0);
      end
      next_cycle();
    end
    idle(4);

    // 5: reset pulse drops an in-flight read (latency 3)
    req_a = 1; wen_a = 0; add_a = 12'h055; ini_add_a = 5'd9;
    @(negedge clk);
    check("t5_gnt_a", 128'(gnt_a[2]), 128'd1);
    next_cycle();
    rst_n = 1'b0; req_b = 1; add_b = 12'h066;
    @(negedge clk);
    check("t5_reset_outputs_dut2", all_outputs(2), '0);
    check("t5_reset_outputs_dut0", all_outputs(0), '0);
    next_cycle();
    rst_n = 1'b1; req_a = 0; req_b = 0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) next_cycle();
      @(negedge clk);
      check($sformatf("t5_no_vld_a_j%0d", j), 128'(vld_a[2]), 128'd0);
    end
    idle(2);

    // 6: MaxStall=0 gives B priority
    req_a = 1; req_b = 1; wen_a = 0; wen_b = 0; add_a = 12'h0A5; add_b = 12'h0B5; ini_add_a = 5'd3;
    @(negedge clk);
    check("t6_gnt_b_dut2", 128'(gnt_b[2]), 128'd1);
    check("t6_gnt_a_dut2", 128'(gnt_a[2]), 128'd0);
    check("t6_gnt_a_dut0", 128'(gnt_a[0]), 128'd1);
    next_cycle();
    req_b = 0;
    @(negedge clk);
    check("t6_gnt_a_c1", 128'(gnt_a[2]), 128'd1);
    next_cycle();
    req_a = 0;
    next_cycle();
    @(negedge clk);
    check("t6_vld_b_c3", 128'(vld_b[2]), 128'd1);
    check("t6_rdata_b_c3", 128'(rdata_b[2]), 128'hC0DE00B5);
    check("t6_vld_a_c3", 128'(vld_a[2]), 128'd0);
    next_cycle();
    @(negedge clk);
    check("t6_vld_a_c4", 128'(vld_a[2]), 128'd1);
    check("t6_rdata_a_c4", 128'(rdata_a[2]), 128'hC0DE00A5);
    check("t6_ini_add_c4", 128'(ini_add_o[2]), 128'd3);
    check("t6_vld_b_c4", 128'(vld_b[2]), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_arbiter.md
Name: tcdm_bank_arbiter

Overview:
- Per-bank controller that shares one fixed-latency SRAM bank between two requesters.
- Port A is one target port of the variable-latency interconnect. Port B is a side port, e.g. a DMA engine.
- Arbitrates each cycle, drives the SRAM, and tracks in-flight reads in a latency pipeline. Each response is routed back to its originating port; port A responses carry the initiator address.
- Instantiated once per bank, next to the interconnect's target response queues. Those queues accept responses unconditionally, so the block applies no response backpressure.

Parameters:
- AddrMemWidth, 12, address bits per bank
- DataWidth, 32, data word width
- BeWidth, DataWidth/8, byte-enable width
- IniAddWidth, 5, initiator-address width on port A (minimum 1)
- MemLatency, 1, SRAM read latency in cycles (≥1)
- MaxStall, 3, consecutive stalled cycles before port B gains priority
- WriteRespOn, 1, writes return a response

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_a_i  in  1  port A request
- gnt_a_o  out  1  port A grant
- ini_add_a_i  in  IniAddWidth  port A initiator address
- add_a_i  in  AddrMemWidth  port A word address
- wen_a_i  in  1  port A write enable
- wdata_a_i  in  DataWidth  port A write data
- be_a_i  in  BeWidth  port A byte enable
- vld_a_o  out  1  port A response valid
- ini_add_a_o  out  IniAddWidth  port A response initiator address
- rdata_a_o  out  DataWidth  port A response data
- req_b_i, gnt_b_o, add_b_i, wen_b_i, wdata_b_i, be_b_i  same widths and directions as port A, for port B
- vld_b_o  out  1  port B response valid
- rdata_b_o  out  DataWidth  port B response data
- mem_req_o  out  1  SRAM request
- mem_add_o  out  AddrMemWidth  SRAM address
- mem_wen_o  out  1  SRAM write enable
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_be_o  out  BeWidth  SRAM byte enable
- mem_rdata_i  in  DataWidth  SRAM read data, valid MemLatency cycles after a request

Behaviour:
- Clocking and reset: single clock clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: every output is 0; the stall counter and the response pipeline are cleared. Asserting reset mid-operation drops all in-flight responses, and none are emitted after release.
- Grants are combinational in the same cycle as the request. At most one grant per cycle.
  - Only A requests: gnt_a_o=1.
  - Only B requests: gnt_b_o=1.
  - Both request: B wins if stall_q==MaxStall, otherwise A wins.
- SRAM drive: mem_req_o = gnt_a_o|gnt_b_o. The mem_* fields mux from the granted port. When neither port is granted, the fields are 0. The SRAM always accepts.
- Stall counter, width $clog2(MaxStall+1):
  - Increments when req_b_i & ~gnt_b_o.
  - Saturates at MaxStall.
  - Clears when gnt_b_o=1 or req_b_i=0.
  - MaxStall=0 means B always has priority.
- Response pipeline: MemLatency stages, each holding {valid, port_sel, ini_add}.
  - Stage 0 loads valid = mem_req_o & (~mem_wen_o | WriteRespOn), port_sel = gnt_b_o, and the port A ini_add.
  - The pipeline shifts every cycle with no stall.
- Response output: when the last stage is valid with port_sel=0, vld_a_o=1, rdata_a_o=mem_rdata_i and ini_add_a_o=stage ini_add. With port_sel=1, vld_b_o=1 and rdata_b_o=mem_rdata_i.
  - Invalid, non-selected and write responses have rdata output 0.
  - Write responses, when enabled, return rdata 0.
- Latency: a response appears exactly MemLatency cycles after its grant cycle. The block sustains one request per cycle, back-to-back.
- Address and ini_add fields pass through unmodified; no arithmetic is performed on them.

Decomposition:
- Package tcdm_bank_pkg holds:
  - resp_tag_t {logic valid; logic port_sel; logic [IniAddWidth-1:0] ini_add}, or a parameterised-width equivalent in the module;
  - port enum PortA=0, PortB=1.
- One natural sub-module, tcdm_bank_resp_pipe: a MemLatency-deep shift register of resp_tag_t with asynchronous reset.

Test Plan:
1. MemLatency=1. A reads add=0x010, ini_add=7 at cycle 0 → gnt_a_o=1 and mem_req_o=1 at cycle 0; at cycle 1, vld_a_o=1, ini_add_a_o=7, rdata_a_o=mem_rdata_i.
2. MaxStall=3. A and B both request every cycle → grant sequence A,A,A,B repeating. B is never starved for more than 3 cycles.
3. WriteRespOn=0. A writes add=0x3, be=0xF, wdata=0xDEADBEEF → SRAM written with those values; no vld_a_o in any cycle.
4. MemLatency=2. A issues reads at cycles 0–3 with ini_add 0,1,2,3 → vld_a_o high in cycles 2–5 with ini_add 0,1,2,3 in order.
5. MemLatency=3. A read at cycle 0; rst_ni pulsed low in cycle 1 → all outputs 0 during reset; no vld_a_o ever appears.
6. MaxStall=0. A and B request together at cycle 0 → gnt_b_o=1, gnt_a_o=0; A granted at cycle 1 once B deasserts; responses arrive on vld_b_o then vld_a_o.
